// File: rtl/secded_codec_pipe_if.sv
// Stream interface for the SECDED codec pipe.
//
// Purpose: carries both the input and the output valid/ready handshakes of the
// codec. The codeword width N and syndrome width P are derived from DATA_W.
// The derivation matches the one inside the codec.
//
// Signals:
//   in_valid, in_ready, in_mode, in_word[N-1:0]    input beat (mode 0 = encode, 1 = decode)
//   out_valid, out_ready, out_word[N-1:0]          output beat
//   out_err_single, out_err_double                 decode classification flags
//   out_syndrome[P-1:0]                            decode syndrome (0 for encode beats)
// Modports:
//   master : the side that produces input beats and consumes output beats
//   slave  : the codec itself
interface secded_codec_pipe_if #(
   parameter int DATA_W = 8
);
   // Smallest P with 2^P >= DATA_W + P + 1.
   function automatic int calc_p(input int dw);
      int p;
      p = 1;
      while ((1 << p) < dw + p + 1) p++;
      return p;
   endfunction

   localparam int P = calc_p(DATA_W);
   localparam int N = DATA_W + P + 1;

   logic         in_valid;
   logic         in_ready;
   logic         in_mode;
   logic [N-1:0] in_word;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_word;
   logic         out_err_single;
   logic         out_err_double;
   logic [P-1:0] out_syndrome;

   modport master (
      output in_valid, in_mode, in_word, out_ready,
      input  in_ready, out_valid, out_word, out_err_single, out_err_double, out_syndrome
   );

   modport slave (
      input  in_valid, in_mode, in_word, out_ready,
      output in_ready, out_valid, out_word, out_err_single, out_err_double, out_syndrome
   );
endinterface

// File: rtl/secded_codec_pipe.sv
// Pipelined SECDED (extended Hamming) encoder/decoder.
//
// Purpose: each beat is either encoded (DATA_W data -> N-bit codeword) or
// decoded and corrected (N-bit codeword -> DATA_W data plus error flags). The
// per-beat in_mode bit selects which. Both modes go through the same two
// register stages, so latency is 2 cycles and beat order is preserved.
// Saturating counters tally corrected and uncorrectable errors seen on output
// handshakes.
//
// Codeword layout: code[k-1] holds Hamming position k (k = 1..N-1). Positions 2^i
// carry parity bits. Data bits fill the remaining positions in ascending order.
// code[N-1] is the overall even-parity bit p0.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   bus       secded_codec_pipe_if.slave; input/output streams, flags and syndrome
//   cnt_clr   synchronous clear of both counters; wins over an increment
//   ce_count  corrected-error count, saturating
//   ue_count  uncorrectable-error count, saturating
module secded_codec_pipe #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   secded_codec_pipe_if.slave bus,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   ce_count,
   output logic [CNT_W-1:0]   ue_count
);

   function automatic int calc_p(input int dw);
      int p;
      p = 1;
      while ((1 << p) < dw + p + 1) p++;
      return p;
   endfunction

   localparam int           P       = calc_p(DATA_W);
   localparam int           N       = DATA_W + P + 1;
   localparam logic [P-1:0] MAX_POS = P'(N - 1);
   localparam logic [N-1:0] ONE     = N'(1);

   // Place data bits at the non-power-of-two positions; every other bit is 0.
   function automatic logic [N-1:0] scatter(input logic [DATA_W-1:0] d);
      logic [N-1:0] r;
      int           j;
      r = '0;
      j = 0;
      for (int k = 1; k < N; k++) begin
         if ((k & (k - 1)) != 0) begin
            r[k-1] = d[j];
            j++;
         end
      end
      return r;
   endfunction

   // Inverse of scatter: pull the data bits back out of a codeword.
   function automatic logic [DATA_W-1:0] gather(input logic [N-1:0] c);
      logic [DATA_W-1:0] r;
      int                j;
      r = '0;
      j = 0;
      for (int k = 1; k < N; k++) begin
         if ((k & (k - 1)) != 0) begin
            r[j] = c[k-1];
            j++;
         end
      end
      return r;
   endfunction

   // Bit i = XOR of every position 1..N-1 whose index has bit i set. For a scattered
   // data word (parity positions zero) this is the parity vector. For a received
   // codeword it is the syndrome.
   function automatic logic [P-1:0] syndrome(input logic [N-1:0] c);
      logic [P-1:0] s;
      s = '0;
      for (int k = 1; k < N; k++) begin
         for (int i = 0; i < P; i++) begin
            if (((k >> i) & 1) != 0) s[i] = s[i] ^ c[k-1];
         end
      end
      return s;
   endfunction

   // Drop the parity bits into positions 2^i, then append the overall parity bit.
   function automatic logic [N-1:0] add_parity(input logic [N-1:0] c, input logic [P-1:0] par);
      logic [N-1:0] r;
      r = c;
      for (int i = 0; i < P; i++) r[(1 << i) - 1] = par[i];
      r[N-1] = ^r[N-2:0];
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   logic             init_q;
   logic             vld_p1_q, vld_p2_q;
   logic             ld1, ld2;
   logic             mode_p1_q;
   logic [N-1:0]     word_p1_q;
   logic [P-1:0]     syn_p1_q;
   logic             chk_p1_q;
   logic [N-1:0]     word_p1_d;
   logic [P-1:0]     syn_p1_d;
   logic [N-1:0]     word_p2_q, word_p2_d;
   logic             single_p2_q, single_p2_d;
   logic             double_p2_q, double_p2_d;
   logic [P-1:0]     syn_p2_q, syn_p2_d;
   logic [N-1:0]     fixed;
   logic [CNT_W-1:0] ce_q, ce_d, ue_q, ue_d;
   logic             out_hs;

   // A stage loads when it is empty or its content is leaving. init_q holds
   // in_ready low until the first clock after reset release.
   assign ld2 = !vld_p2_q | bus.out_ready;
   assign ld1 = init_q & (!vld_p1_q | ld2);

   // ---- Stage 1: parity (encode) or syndrome + overall check (decode) ----
   // Encode keeps the scattered data word so the parity bits can be inserted later.
   assign word_p1_d = bus.in_mode ? bus.in_word : scatter(bus.in_word[DATA_W-1:0]);
   assign syn_p1_d  = syndrome(word_p1_d);

   always_ff @(posedge clk) begin
      if (ld1 && bus.in_valid) begin
         mode_p1_q <= bus.in_mode;
         word_p1_q <= word_p1_d;
         syn_p1_q  <= syn_p1_d;
         chk_p1_q  <= ^bus.in_word;
      end
   end

   // ---- Stage 2: codeword assembly or classification and correction ----
   always_comb begin
      word_p2_d   = '0;
      single_p2_d = 1'b0;
      double_p2_d = 1'b0;
      syn_p2_d    = '0;
      fixed       = word_p1_q;
      if (!mode_p1_q) begin
         word_p2_d = add_parity(word_p1_q, syn_p1_q);
      end else begin
         syn_p2_d = syn_p1_q;
         if (chk_p1_q) begin
            // Odd overall parity: one bit flipped, unless it points past the codeword.
            if (syn_p1_q == '0) begin
               single_p2_d = 1'b1;
            end else if (syn_p1_q <= MAX_POS) begin
               single_p2_d = 1'b1;
               fixed       = word_p1_q ^ (ONE << (syn_p1_q - 1'b1));
            end else begin
               double_p2_d = 1'b1;
            end
         end else if (syn_p1_q != '0) begin
            double_p2_d = 1'b1;
         end
         word_p2_d = {{(P + 1){1'b0}}, gather(fixed)};
      end
   end

   assign out_hs = vld_p2_q & bus.out_ready;

   always_comb begin
      ce_d = ce_q;
      ue_d = ue_q;
      if (cnt_clr) begin
         ce_d = '0;
         ue_d = '0;
      end else if (out_hs) begin
         if (single_p2_q) ce_d = sat_inc(ce_q);
         if (double_p2_q) ue_d = sat_inc(ue_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_q      <= 1'b0;
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         word_p2_q   <= '0;
         single_p2_q <= 1'b0;
         double_p2_q <= 1'b0;
         syn_p2_q    <= '0;
         ce_q        <= '0;
         ue_q        <= '0;
      end else begin
         init_q <= 1'b1;
         ce_q   <= ce_d;
         ue_q   <= ue_d;
         if (ld1) vld_p1_q <= bus.in_valid;
         if (ld2) vld_p2_q <= vld_p1_q;
         // Output fields only change when a new beat moves in, so they stay put under backpressure.
         if (ld2 && vld_p1_q) begin
            word_p2_q   <= word_p2_d;
            single_p2_q <= single_p2_d;
            double_p2_q <= double_p2_d;
            syn_p2_q    <= syn_p2_d;
         end
      end
   end

   assign bus.in_ready       = ld1;
   assign bus.out_valid      = vld_p2_q;
   assign bus.out_word       = word_p2_q;
   assign bus.out_err_single = single_p2_q;
   assign bus.out_err_double = double_p2_q;
   assign bus.out_syndrome   = syn_p2_q;
   assign ce_count           = ce_q;
   assign ue_count           = ue_q;

endmodule

// File: tb/tb_secded_codec_pipe.sv
module tb_secded_codec_pipe;

   typedef struct packed {
      logic [12:0] word;
      logic        s;
      logic        d;
      logic [3:0]  syn;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr0, clr1;
   logic [15:0] ce0, ue0;
   logic [1:0]  ce1, ue1;

   beat_t       sb[$];
   beat_t       got_q[$];
   beat_t       exp_q[$];
   int          lat_q[$];
   logic        timed_out;
   logic [12:0] in_words[8];
   beat_t       in_exp[8];
   int          n_chk = 0;
   int          n_fail = 0;

   secded_codec_pipe_if #(.DATA_W(8)) bus0 ();
   secded_codec_pipe_if #(.DATA_W(8)) bus1 ();

   secded_codec_pipe #(.DATA_W(8), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .cnt_clr(clr0), .ce_count(ce0), .ue_count(ue0)
   );

   secded_codec_pipe #(.DATA_W(8), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .cnt_clr(clr1), .ce_count(ce1), .ue_count(ue1)
   );

   always #5 clk = ~clk;

   // One cycle on dut0: drive at the negedge, sample 1 ns later, then step to the next negedge.
   task automatic cyc0(input logic v, input logic m, input logic [12:0] w, input logic ordy,
                       output logic acc, output logic hs, output logic ov, output beat_t got);
      bus0.in_valid  = v;
      bus0.in_mode   = m;
      bus0.in_word   = w;
      bus0.out_ready = ordy;
      #1;
      acc = v & bus0.in_ready;
      ov  = bus0.out_valid;
      hs  = bus0.out_valid & ordy;
      got = {bus0.out_word, bus0.out_err_single, bus0.out_err_double, bus0.out_syndrome};
      @(posedge clk);
      @(negedge clk);
   endtask

   // One cycle on dut1. When clr_hs is set, cnt_clr is raised in a cycle that carries a handshake.
   task automatic cyc1(input logic v, input logic [12:0] w, input logic clr_hs,
                       output logic acc, output logic hs, output beat_t got);
      bus1.in_valid  = v;
      bus1.in_mode   = 1'b1;
      bus1.in_word   = w;
      bus1.out_ready = 1'b1;
      #1;
      acc  = v & bus1.in_ready;
      hs   = bus1.out_valid;
      got  = {bus1.out_word, bus1.out_err_single, bus1.out_err_double, bus1.out_syndrome};
      clr1 = clr_hs & bus1.out_valid;
      @(posedge clk);
      @(negedge clk);
      clr1 = 1'b0;
   endtask

   // Streams nb beats from in_words through dut0 with out_ready high. Expectations
   // enter the scoreboard on acceptance. Each handshake pairs the observed beat with
   // the popped expectation, along with its latency in cycles.
   task automatic stream0(input logic mode, input int nb);
      int    i;
      int    cyc;
      int    stamps[$];
      logic  acc, hs, ov;
      beat_t got;
      i = 0;
      cyc = 0;
      got_q.delete();
      exp_q.delete();
      lat_q.delete();
      while ((i < nb || sb.size() != 0) && cyc < 40) begin
         cyc0(i < nb, mode, (i < nb) ? in_words[i] : 13'h0, 1'b1, acc, hs, ov, got);
         if (hs && sb.size() != 0) begin
            exp_q.push_back(sb.pop_front());
            got_q.push_back(got);
            lat_q.push_back(cyc - stamps.pop_front());
         end
         if (acc) begin
            sb.push_back(in_exp[i]);
            stamps.push_back(cyc);
            i++;
         end
         cyc++;
      end
      timed_out = (cyc >= 40);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      clr0 = 1'b0;
      clr1 = 1'b0;
      bus0.in_valid = 1'b0; bus0.in_mode = 1'b0; bus0.in_word = '0; bus0.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_mode = 1'b0; bus1.in_word = '0; bus1.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus0.out_valid); end
      n_chk++;
      if ({bus0.out_word, bus0.out_err_single, bus0.out_err_double, bus0.out_syndrome} !== 19'h0) begin
         n_fail++;
         $display("FAIL rst_out_fields: got word %h s %b d %b syn %h expected all 0",
                  bus0.out_word, bus0.out_err_single, bus0.out_err_double, bus0.out_syndrome);
      end
      n_chk++;
      if (ce0 !== 16'h0 || ue0 !== 16'h0) begin n_fail++; $display("FAIL rst_counters: got ce %0d ue %0d expected 0 0", ce0, ue0); end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", bus0.in_ready); end
      n_chk++;
      if (bus1.out_valid !== 1'b0 || ce1 !== 2'd0) begin n_fail++; $display("FAIL rst_dut1: got out_valid %b ce %0d expected 0 0", bus1.out_valid, ce1); end
   endtask

   task automatic test_encode;
      in_words[0] = 13'h000; in_exp[0] = {13'h0000, 1'b0, 1'b0, 4'd0};
      in_words[1] = 13'h0FF; in_exp[1] = {13'h0F77, 1'b0, 1'b0, 4'd0};
      in_words[2] = 13'h011; in_exp[2] = {13'h0186, 1'b0, 1'b0, 4'd0};
      stream0(1'b0, 3);
      n_chk++;
      if (timed_out !== 1'b0 || got_q.size() != 3) begin n_fail++; $display("FAIL enc_count: got %0d beats expected 3", got_q.size()); end
      foreach (got_q[k]) begin
         n_chk++;
         if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL enc_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
         n_chk++;
         if (lat_q[k] != 2) begin n_fail++; $display("FAIL enc_latency%0d: got %0d expected 2", k, lat_q[k]); end
      end
   endtask

   task automatic test_decode_single;
      in_words[0] = 13'h0F77; in_exp[0] = {13'h00FF, 1'b0, 1'b0, 4'd0};
      in_words[1] = 13'h0F57; in_exp[1] = {13'h00FF, 1'b1, 1'b0, 4'd6};
      in_words[2] = 13'h1F77; in_exp[2] = {13'h00FF, 1'b1, 1'b0, 4'd0};
      stream0(1'b1, 3);
      n_chk++;
      if (timed_out !== 1'b0 || got_q.size() != 3) begin n_fail++; $display("FAIL dec1_count: got %0d beats expected 3", got_q.size()); end
      foreach (got_q[k]) begin
         n_chk++;
         if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL dec1_beat%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
      end
      n_chk++;
      if (ce0 !== 16'd2 || ue0 !== 16'd0) begin n_fail++; $display("FAIL dec1_counters: got ce %0d ue %0d expected 2 0", ce0, ue0); end
   endtask

   task automatic test_decode_double;
      in_words[0] = 13'h0F74; in_exp[0] = {13'h00FF, 1'b0, 1'b1, 4'd3};
      stream0(1'b1, 1);
      n_chk++;
      if (timed_out !== 1'b0 || got_q.size() != 1) begin n_fail++; $display("FAIL dec2_count: got %0d beats expected 1", got_q.size()); end
      foreach (got_q[k]) begin
         n_chk++;
         if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL dec2_beat: got %h expected %h", got_q[k], exp_q[k]); end
      end
      n_chk++;
      if (ce0 !== 16'd2 || ue0 !== 16'd1) begin n_fail++; $display("FAIL dec2_counters: got ce %0d ue %0d expected 2 1", ce0, ue0); end
   endtask

   task automatic test_backpressure;
      int    i;
      int    cyc;
      int    nout;
      logic  acc, hs, ov;
      beat_t got, e;
      in_words[0] = 13'h000; in_exp[0] = {13'h0000, 1'b0, 1'b0, 4'd0};
      in_words[1] = 13'h0FF; in_exp[1] = {13'h0F77, 1'b0, 1'b0, 4'd0};
      in_words[2] = 13'h011; in_exp[2] = {13'h0186, 1'b0, 1'b0, 4'd0};
      sb.delete();
      i = 0;
      for (int c = 0; c < 5; c++) begin
         cyc0(i < 3, 1'b0, (i < 3) ? in_words[i] : 13'h0, 1'b0, acc, hs, ov, got);
         if (ov && sb.size() != 0) begin
            n_chk++;
            if (got !== sb[0]) begin n_fail++; $display("FAIL bp_held%0d: got %h expected %h", c, got, sb[0]); end
         end
         if (acc) begin sb.push_back(in_exp[i]); i++; end
      end
      n_chk++;
      if (i != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", i); end
      n_chk++;
      if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bus0.in_ready); end
      nout = 0;
      cyc = 0;
      while ((i < 3 || sb.size() != 0) && cyc < 40) begin
         cyc0(i < 3, 1'b0, (i < 3) ? in_words[i] : 13'h0, 1'b1, acc, hs, ov, got);
         if (hs && sb.size() != 0) begin
            e = sb.pop_front();
            nout++;
            n_chk++;
            if (got !== e) begin n_fail++; $display("FAIL bp_order%0d: got %h expected %h", nout, got, e); end
         end
         if (acc) begin sb.push_back(in_exp[i]); i++; end
         cyc++;
      end
      n_chk++;
      if (nout != 3) begin n_fail++; $display("FAIL bp_drained: got %0d beats expected 3", nout); end
   endtask

   task automatic test_saturation;
      int         i;
      int         cyc;
      int         nb;
      logic       acc, hs;
      beat_t      got, e;
      logic [1:0] want;
      sb.delete();
      for (int ph = 0; ph < 2; ph++) begin
         nb   = (ph == 0) ? 5 : 1;
         want = (ph == 0) ? 2'd3 : 2'd0;
         i = 0;
         cyc = 0;
         while ((i < nb || sb.size() != 0) && cyc < 40) begin
            cyc1(i < nb, 13'h0F57, ph == 1, acc, hs, got);
            if (hs && sb.size() != 0) begin
               e = sb.pop_front();
               n_chk++;
               if (got !== e) begin n_fail++; $display("FAIL sat_beat_ph%0d: got %h expected %h", ph, got, e); end
            end
            if (acc) begin sb.push_back({13'h00FF, 1'b1, 1'b0, 4'd6}); i++; end
            cyc++;
         end
         n_chk++;
         if (cyc >= 40) begin n_fail++; $display("FAIL sat_timeout_ph%0d: got %0d cycles expected under 40", ph, cyc); end
         n_chk++;
         if (ce1 !== want) begin n_fail++; $display("FAIL sat_ce_ph%0d: got %0d expected %0d", ph, ce1, want); end
      end
      n_chk++;
      if (ue1 !== 2'd0) begin n_fail++; $display("FAIL sat_ue: got %0d expected 0", ue1); end
   endtask

   task automatic test_reset_mid;
      logic  acc, hs, ov;
      beat_t got;
      for (int c = 0; c < 3; c++) cyc0(c == 0, 1'b0, 13'h0FF, 1'b0, acc, hs, ov, got);
      n_chk++;
      if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus0.out_valid); end
      n_chk++;
      if (ce0 !== 16'd2 || ue0 !== 16'd1) begin n_fail++; $display("FAIL mid_pre_counters: got ce %0d ue %0d expected 2 1", ce0, ue0); end
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", bus0.out_valid); end
      n_chk++;
      if (ce0 !== 16'd0 || ue0 !== 16'd0) begin n_fail++; $display("FAIL mid_counters: got ce %0d ue %0d expected 0 0", ce0, ue0); end
      n_chk++;
      if (bus0.out_word !== 13'h0) begin n_fail++; $display("FAIL mid_out_word: got %h expected 0000", bus0.out_word); end
      sb.delete();
      bus0.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_words[0] = 13'h0FF; in_exp[0] = {13'h0F77, 1'b0, 1'b0, 4'd0};
      stream0(1'b0, 1);
      n_chk++;
      if (timed_out !== 1'b0 || got_q.size() != 1) begin n_fail++; $display("FAIL mid_post_count: got %0d beats expected 1", got_q.size()); end
      foreach (got_q[k]) begin
         n_chk++;
         if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL mid_post_beat: got %h expected %h", got_q[k], exp_q[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_encode();
      test_decode_single();
      test_decode_double();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/secded_codec_pipe.md
Name: secded_codec_pipe

Overview:
- Parametrised, pipelined SECDED (extended Hamming) codec; successor to the fixed 8-bit combinational encoder.
- Encodes DATA_W-bit words into N-bit codewords, or decodes and corrects codewords, selected per beat by a mode bit.
- Sits between the memory controller datapath and the array interface. Uses valid/ready handshakes on both sides and keeps saturating corrected/uncorrectable error counters for status reporting.

Parameters:
DATA_W, 8, data width (4..64)
CNT_W, 16, width of each error counter
P, derived, smallest integer with 2^P >= DATA_W+P+1 (4 for DATA_W=8)
N, derived, DATA_W+P+1 codeword width (13 for DATA_W=8)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_mode  in  1  0 = encode, 1 = decode; sampled with the beat
in_word  in  N  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_word  out  N  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0
out_err_single  out  1  decode only: single-bit error corrected
out_err_double  out  1  decode only: uncorrectable error detected
out_syndrome  out  P  decode: Hamming syndrome; encode: 0
cnt_clr  in  1  synchronous clear of both counters
ce_count  out  CNT_W  corrected-error count, saturating
ue_count  out  CNT_W  uncorrectable-error count, saturating

Behaviour:
- Clocking and reset: one clock; rst is asynchronous and active-high.
- Codeword layout: code[k-1] holds Hamming position k, for k = 1..N-1.
  - Positions 2^i hold parity bit p(2^i).
  - Data bits fill the remaining positions in ascending order, d0 lowest (d0 at position 3 for DATA_W=8).
  - code[N-1] = p0 = XOR of code[N-2:0] (even overall parity).
- Parity bit p(2^i) = XOR of all data positions whose index has bit i set.
- Pipeline: two register stages, both modes take the same path, so latency is 2 cycles for every beat and order is preserved. No combinational path from in_* to out_*.
  - Stage 1 encode: computes parity bits.
  - Stage 1 decode: computes syndrome s (P bits) and overall check q = XOR of all N bits.
  - Stage 2: assembles the codeword, or classifies and corrects the beat.
- Handshake:
  - A beat transfers on in_valid&in_ready and on out_valid&out_ready.
  - Each stage advances when it is empty or the next stage is advancing.
  - in_ready = !stage1_valid | stage1_advance.
  - Full throughput of 1 beat/cycle when out_ready stays high. Up to 2 beats are held under backpressure.
  - out_word and the flags stay stable while out_valid & !out_ready.
- Decode classification:
  - s=0, q=0: no error; both flags 0.
  - q=1, s=0: p0 bit flipped; data unchanged; err_single=1.
  - q=1, 1<=s<=N-1: flip position s; err_single=1.
  - q=1, s>N-1: invalid position; err_double=1; data passed uncorrected.
  - q=0, s!=0: double error; err_double=1; data extracted uncorrected.
- Counters:
  - ce_count increments on an output handshake with err_single; ue_count increments on one with err_double.
  - Both saturate at all-ones.
  - cnt_clr wins over a same-cycle increment.
- Reset values: all stage valids 0, in_ready 1 one cycle after reset release, out_valid 0, out_word 0, flags 0, out_syndrome 0, both counters 0.
- Reset mid-operation: in-flight beats are discarded and out_valid drops immediately.

Test Plan:
- Encode, DATA_W=8, out_ready=1: beats 0x00, 0xFF, 0x11 back-to-back -> out_word 13'h0000, 13'h0F77, 13'h0186 on 3 consecutive cycles, first one 2 cycles after the input; flags 0.
- Decode clean and single error: 13'h0F77 -> 0xFF, no flags, syndrome 0. 13'h0F57 (position 6 flipped) -> 0xFF, err_single=1, syndrome 6, ce_count=1. 13'h1F77 (p0 flipped) -> 0xFF, err_single=1, syndrome 0, ce_count=2.
- Decode double error: 13'h0F74 (positions 1 and 2 flipped) -> err_double=1, syndrome 3, data 0xFF, ue_count=1, ce_count unchanged.
- Backpressure: out_ready=0 while 3 beats are offered -> in_ready drops after 2 accepted, out_word held stable. Release out_ready -> all 3 beats emerge in order with none lost.
- Counter saturation with CNT_W=2: 5 single-error beats -> ce_count = 3. Pulse cnt_clr in the same cycle as a 6th single-error handshake -> ce_count = 0.
- Reset mid-operation: assert rst while out_valid=1 and the counters are nonzero -> out_valid=0 and both counters 0 immediately. After rst is released, the next encode of 0xFF produces 13'h0F77.
